// File: rtl/ser4_ctrl_if.sv
// Handshake and mux-drive bundle between a word producer, ser4_ctrl and a downstream mux4_1.
interface ser4_ctrl_if;
    logic       load;
    logic [3:0] din;
    logic       ready;
    logic       a;
    logic       b;
    logic       c;
    logic       d;
    logic [1:0] s;
    logic       valid;
    logic       last;

    modport slave (
        input  load, din,
        output ready, a, b, c, d, s, valid, last
    );

    modport master (
        output load, din,
        input  ready, a, b, c, d, s, valid, last
    );
endinterface

// File: rtl/ser4_ctrl.sv
// 4-bit parallel-to-serial controller driving mux4_1 (LSB first, each select held HOLD clocks).
// Optional back-to-back streaming: define SER4_AUTORELOAD_EN to accept a new word on the last bit.
module ser4_ctrl #(
    parameter int HOLD = 1
) (
    input  logic         clk,
    input  logic         reset,
    ser4_ctrl_if.slave   bus
);
    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [3:0] HOLD_M1 = 4'(HOLD - 1);

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [1:0] s, s_n;
    logic [3:0] data, data_n;
    logic       valid, valid_n;
    logic       last;

    assign last = (state == SHIFT) && (cnt == HOLD_M1) && (s == 2'b11);

`ifdef SER4_AUTORELOAD_EN
    assign bus.ready = (state == IDLE) || last;
`else
    assign bus.ready = (state == IDLE);
`endif

    assign bus.a     = data[0];
    assign bus.b     = data[1];
    assign bus.c     = data[2];
    assign bus.d     = data[3];
    assign bus.s     = s;
    assign bus.valid = valid;
    assign bus.last  = last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            s     <= '0;
            data  <= '0;
            valid <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            s     <= s_n;
            data  <= data_n;
            valid <= valid_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        s_n     = s;
        data_n  = data;
        valid_n = valid;
        case (state)
            IDLE: begin
                if (bus.load) begin
                    data_n  = bus.din;
                    s_n     = 2'b00;
                    cnt_n   = '0;
                    valid_n = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt != HOLD_M1) begin
                    cnt_n = cnt + 4'd1;
                end else if (s != 2'b11) begin
                    s_n   = s + 2'b01;
                    cnt_n = '0;
                end else begin
                    // End of word; a_..d_ keep the last word so the mux output stays stable.
                    state_n = IDLE;
                    valid_n = 1'b0;
                    s_n     = 2'b00;
                    cnt_n   = '0;
`ifdef SER4_AUTORELOAD_EN
                    if (bus.load) begin
                        state_n = SHIFT;
                        valid_n = 1'b1;
                        data_n  = bus.din;
                    end
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ser4_ctrl.sv
// Scoreboard bench for ser4_ctrl: stimulus pushes expected serial bits, per-DUT monitors pop and compare.
module tb_ser4_ctrl;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

`ifdef SER4_AUTORELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    ser4_ctrl_if bus1();
    ser4_ctrl_if bus3();

    ser4_ctrl #(.HOLD(1)) u1 (.clk(clk), .reset(reset), .bus(bus1));
    ser4_ctrl #(.HOLD(3)) u3 (.clk(clk), .reset(reset), .bus(bus3));

    typedef struct {
        logic bit_v;
        logic last;
        logic ready;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic logic mux4(input logic a, input logic b, input logic c,
                                  input logic d, input logic [1:0] s);
        case (s)
            2'b00:   return a;
            2'b01:   return b;
            2'b10:   return c;
            default: return d;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Expected stream for nbits select positions of word w (ready only rises on last with autoreload).
    task automatic push(input int sel, input logic [3:0] w, input int hold, input int nbits);
        exp_t e;
        for (int i = 0; i < nbits; i++) begin
            for (int h = 0; h < hold; h++) begin
                e.bit_v = w[i];
                e.last  = (i == 3) && (h == hold - 1);
                e.ready = e.last & AUTO;
                if (sel == 1) q1.push_back(e);
                else          q3.push_back(e);
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus1.valid === 1'b1) begin
            if (q1.size() == 0) begin
                check("u1_unexpected_valid", 1, 0);
            end else begin
                e = q1.pop_front();
                check("u1_mux_out", 32'(mux4(bus1.a, bus1.b, bus1.c, bus1.d, bus1.s)), 32'(e.bit_v));
                check("u1_last", 32'(bus1.last), 32'(e.last));
                check("u1_ready", 32'(bus1.ready), 32'(e.ready));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus3.valid === 1'b1) begin
            if (q3.size() == 0) begin
                check("u3_unexpected_valid", 1, 0);
            end else begin
                e = q3.pop_front();
                check("u3_mux_out", 32'(mux4(bus3.a, bus3.b, bus3.c, bus3.d, bus3.s)), 32'(e.bit_v));
                check("u3_last", 32'(bus3.last), 32'(e.last));
                check("u3_ready", 32'(bus3.ready), 32'(e.ready));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [8:0] vseq;
        logic [8:0] vseq_exp;
        logic       drop;
        int         n;

        reset = 1'b1;
        bus1.load = 1'b1; bus1.din = 4'b1111;
        bus3.load = 1'b1; bus3.din = 4'b1111;

        // Reset dominates a pending load.
        repeat (3) step();
        check("rst_abcd", 32'({bus1.d, bus1.c, bus1.b, bus1.a}), 32'h0);
        check("rst_s", 32'(bus1.s), 32'h0);
        check("rst_valid", 32'(bus1.valid), 32'h0);
        check("rst_ready", 32'(bus1.ready), 32'h1);
        check("rst_last", 32'(bus1.last), 32'h0);
        check("rst_u3_valid", 32'(bus3.valid), 32'h0);
        bus1.load = 1'b0; bus3.load = 1'b0;
        reset = 1'b0;
        step();
        check("post_rst_ready", 32'(bus1.ready), 32'h1);
        check("post_rst_valid", 32'(bus1.valid), 32'h0);

        // Single word, HOLD=1.
        push(1, 4'b1010, 1, 4);
        bus1.load = 1'b1; bus1.din = 4'b1010;
        step();
        bus1.load = 1'b0;
        check("single_s0", 32'(bus1.s), 32'h0);
        repeat (4) step();
        check("single_idle_valid", 32'(bus1.valid), 32'h0);
        check("single_idle_ready", 32'(bus1.ready), 32'h1);
        check("single_idle_s", 32'(bus1.s), 32'h0);
        check("single_retain", 32'({bus1.d, bus1.c, bus1.b, bus1.a}), 32'ha);

        // Streaming with load held high.
        push(1, 4'b0110, 1, 4);
        push(1, 4'b1001, 1, 4);
        bus1.load = 1'b1; bus1.din = 4'b0110;
        step();
        bus1.din = 4'b1001;
        drop = 1'b0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            vseq[k] = bus1.valid;
            if (bus1.load && bus1.ready) drop = 1'b1;
            step();
            if (drop) bus1.load = 1'b0;
        end
        vseq_exp = AUTO ? 9'b0_1111_1111 : 9'b1_1110_1111;
        check("stream_valid_seq", 32'(vseq), 32'(vseq_exp));
        repeat (2) step();

        // HOLD=3 on the second instance.
        push(3, 4'b1100, 3, 4);
        bus3.load = 1'b1; bus3.din = 4'b1100;
        step();
        bus3.load = 1'b0;
        n = 0;
        for (int k = 0; k < 20 && bus3.valid === 1'b1; k++) begin
            n++;
            step();
        end
        check("hold3_valid_cycles", 32'(n), 32'd12);
        check("hold3_idle_ready", 32'(bus3.ready), 32'h1);

        // Reset while s=10 discards the word.
        push(1, 4'b1011, 1, 3);
        bus1.load = 1'b1; bus1.din = 4'b1011;
        step();
        bus1.load = 1'b0;
        step();
        step();
        check("midrst_s_before", 32'(bus1.s), 32'h2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_valid", 32'(bus1.valid), 32'h0);
        check("midrst_s", 32'(bus1.s), 32'h0);
        check("midrst_abcd", 32'({bus1.d, bus1.c, bus1.b, bus1.a}), 32'h0);
        check("midrst_ready", 32'(bus1.ready), 32'h1);

        push(1, 4'b0001, 1, 4);
        bus1.load = 1'b1; bus1.din = 4'b0001;
        step();
        bus1.load = 1'b0;
        repeat (6) step();

        check("q1_drained", 32'(q1.size()), 32'd0);
        check("q3_drained", 32'(q3.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
